// File: rtl/karatsuba_pkg.sv
// ---------------------------------------------------------------------------
// karatsuba_pkg
// Shared constants and sizing helpers for the Karatsuba multiplier family.
//   KMUL_STAGES    number of register stages in the one-level pipeline
//   KMUL_MID_GROW  extra bits the (aL+aH)*(bL+bH) term needs over 2H
//   kmul_half(w)   half operand width H
//   kmul_mid_w(w)  width of the middle partial product z1 (2H+2)
// ---------------------------------------------------------------------------
package karatsuba_pkg;

    localparam int unsigned KMUL_STAGES   = 3;
    localparam int unsigned KMUL_MID_GROW = 2;

    function automatic int unsigned kmul_half(input int unsigned w);
        return w / 2;
    endfunction

    function automatic int unsigned kmul_mid_w(input int unsigned w);
        return 2 * kmul_half(w) + KMUL_MID_GROW;
    endfunction

endpackage

// File: rtl/karatsuba_mult_pipe_if.sv
// ---------------------------------------------------------------------------
// karatsuba_mult_pipe_if
// Streaming operand/result bundle for karatsuba_mult_pipe.
//   in_valid/in_ready/in_a/in_b/in_tag       operand side (valid/ready)
//   out_valid/out_ready/out_product/out_tag  result side (valid/ready)
//   busy                                     any pipeline stage occupied
// Modports: master = producer/consumer side, slave = the multiplier.
// ---------------------------------------------------------------------------
interface karatsuba_mult_pipe_if #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned TAG_W = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic [TAG_W-1:0]     in_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_product;
    logic [TAG_W-1:0]     out_tag;
    logic                 busy;

    modport master (
        output in_valid, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_product, out_tag, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_product, out_tag, busy
    );
endinterface

// File: rtl/karatsuba_pp_stage.sv
// ---------------------------------------------------------------------------
// karatsuba_pp_stage
// Second pipeline register: forms and holds the three Karatsuba partial
// products z0 = aL*bL, z2 = aH*bH, z1 = (aL+aH)*(bL+bH) with valid and sideband.
//   clk, rst        clock, asynchronous active-high reset
//   advance         load enable (stage may take the upstream item / bubble)
//   in_valid        upstream stage holds an item
//   al, ah, bl, bh  operand halves (H bits)
//   sa, sb          half sums with carry (H+1 bits)
//   in_side         sideband (tag, plus sign in the signed build)
//   valid, z0, z2, z1, side   registered outputs
// ---------------------------------------------------------------------------
module karatsuba_pp_stage
    import karatsuba_pkg::*;
#(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned SIDE_W = 4,
    localparam int unsigned H     = kmul_half(WIDTH),
    localparam int unsigned MID_W = kmul_mid_w(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              advance,
    input  logic              in_valid,
    input  logic [H-1:0]      al,
    input  logic [H-1:0]      ah,
    input  logic [H-1:0]      bl,
    input  logic [H-1:0]      bh,
    input  logic [H:0]        sa,
    input  logic [H:0]        sb,
    input  logic [SIDE_W-1:0] in_side,
    output logic              valid,
    output logic [2*H-1:0]    z0,
    output logic [2*H-1:0]    z2,
    output logic [MID_W-1:0]  z1,
    output logic [SIDE_W-1:0] side
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            z0    <= '0;
            z2    <= '0;
            z1    <= '0;
            side  <= '0;
        end else if (advance) begin
            valid <= in_valid;
            if (in_valid) begin
                z0   <= {{H{1'b0}}, al} * {{H{1'b0}}, bl};
                z2   <= {{H{1'b0}}, ah} * {{H{1'b0}}, bh};
                z1   <= {{(H+1){1'b0}}, sa} * {{(H+1){1'b0}}, sb};
                side <= in_side;
            end
        end
    end

endmodule

// File: rtl/karatsuba_mult_pipe.sv
// ---------------------------------------------------------------------------
// karatsuba_mult_pipe
// Fully pipelined one-level Karatsuba multiplier, WIDTH x WIDTH -> 2*WIDTH,
// valid/ready streaming with backpressure, one result per cycle sustained,
// sideband tag carried alongside. Three stages: S1 split/sum, S2 partial
// products (karatsuba_pp_stage), S3 recombination into the output register.
//   clk   rising-edge clock
//   rst   asynchronous active-high reset; discards every in-flight item
//   bus   karatsuba_mult_pipe_if.slave (in_*, out_*, busy)
// Build option: define KARATSUBA_SIGNED_EN for two's-complement operands
// (magnitudes multiplied, result negated in S3 when the signs differ).
// in_ready is combinational from out_ready through the advance chain.
// ---------------------------------------------------------------------------
module karatsuba_mult_pipe
    import karatsuba_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned TAG_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    karatsuba_mult_pipe_if.slave  bus
);

    localparam int unsigned H     = kmul_half(WIDTH);
    localparam int unsigned MID_W = kmul_mid_w(WIDTH);
    localparam int unsigned PW    = 2 * WIDTH;
`ifdef KARATSUBA_SIGNED_EN
    localparam int unsigned SIDE_W = TAG_W + 1;   // {sign, tag}
`else
    localparam int unsigned SIDE_W = TAG_W;
`endif

    // ---------------- advance chain ----------------
    logic s1_valid, s2_valid, out_valid_q;
    logic s1_adv, s2_adv, s3_adv;

    always_comb begin
        s3_adv = !out_valid_q || bus.out_ready;
        s2_adv = !s2_valid || s3_adv;
        s1_adv = !s1_valid || s2_adv;
    end

    // ---------------- operand preparation ----------------
    logic [WIDTH-1:0]  op_a, op_b;
    logic [SIDE_W-1:0] op_side;

    always_comb begin
`ifdef KARATSUBA_SIGNED_EN
        // Unsigned WIDTH-bit magnitude represents -2^(W-1) exactly.
        op_a    = bus.in_a[WIDTH-1] ? ('0 - bus.in_a) : bus.in_a;
        op_b    = bus.in_b[WIDTH-1] ? ('0 - bus.in_b) : bus.in_b;
        op_side = {bus.in_a[WIDTH-1] ^ bus.in_b[WIDTH-1], bus.in_tag};
`else
        op_a    = bus.in_a;
        op_b    = bus.in_b;
        op_side = bus.in_tag;
`endif
    end

    // ---------------- S1: split and half sums ----------------
    logic [H-1:0]      s1_al, s1_ah, s1_bl, s1_bh;
    logic [H:0]        s1_sa, s1_sb;
    logic [SIDE_W-1:0] s1_side;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_al    <= '0;
            s1_ah    <= '0;
            s1_bl    <= '0;
            s1_bh    <= '0;
            s1_sa    <= '0;
            s1_sb    <= '0;
            s1_side  <= '0;
        end else if (s1_adv) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_al   <= op_a[H-1:0];
                s1_ah   <= op_a[WIDTH-1:H];
                s1_bl   <= op_b[H-1:0];
                s1_bh   <= op_b[WIDTH-1:H];
                s1_sa   <= {1'b0, op_a[H-1:0]} + {1'b0, op_a[WIDTH-1:H]};
                s1_sb   <= {1'b0, op_b[H-1:0]} + {1'b0, op_b[WIDTH-1:H]};
                s1_side <= op_side;
            end
        end
    end

    // ---------------- S2: partial products ----------------
    logic [2*H-1:0]    z0, z2;
    logic [MID_W-1:0]  z1;
    logic [SIDE_W-1:0] s2_side;

    karatsuba_pp_stage #(
        .WIDTH  (WIDTH),
        .SIDE_W (SIDE_W)
    ) u_pp (
        .clk      (clk),
        .rst      (rst),
        .advance  (s2_adv),
        .in_valid (s1_valid),
        .al       (s1_al),
        .ah       (s1_ah),
        .bl       (s1_bl),
        .bh       (s1_bh),
        .sa       (s1_sa),
        .sb       (s1_sb),
        .in_side  (s1_side),
        .valid    (s2_valid),
        .z0       (z0),
        .z2       (z2),
        .z1       (z1),
        .side     (s2_side)
    );

    // ---------------- S3: recombination ----------------
    // The exact sum fits in 2*WIDTH bits, so it is formed modulo 2^(2*WIDTH)
    // rather than at 2*WIDTH+2 bits; the dropped top bits are always zero.
    logic [MID_W-1:0] mid;
    logic [PW-1:0]    mag;
    logic [PW-1:0]    result;
    logic [TAG_W-1:0] result_tag;

    always_comb begin
        mid = z1 - {{KMUL_MID_GROW{1'b0}}, z2} - {{KMUL_MID_GROW{1'b0}}, z0};
        mag = ({{(PW-2*H){1'b0}}, z2} << (2*H))
            + ({{(PW-MID_W){1'b0}}, mid} << H)
            + {{(PW-2*H){1'b0}}, z0};
`ifdef KARATSUBA_SIGNED_EN
        result     = s2_side[TAG_W] ? ('0 - mag) : mag;
        result_tag = s2_side[TAG_W-1:0];
`else
        result     = mag;
        result_tag = s2_side;
`endif
    end

    logic [PW-1:0]    out_product_q;
    logic [TAG_W-1:0] out_tag_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q   <= 1'b0;
            out_product_q <= '0;
            out_tag_q     <= '0;
        end else if (s3_adv) begin
            out_valid_q <= s2_valid;
            if (s2_valid) begin
                out_product_q <= result;
                out_tag_q     <= result_tag;
            end
        end
    end

    assign bus.in_ready    = s1_adv;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_product = out_product_q;
    assign bus.out_tag     = out_tag_q;
    assign bus.busy        = s1_valid | s2_valid | out_valid_q;

endmodule

// File: tb/tb_karatsuba_mult_pipe.sv
// ---------------------------------------------------------------------------
// tb_karatsuba_mult_pipe
// Self-checking bench for karatsuba_mult_pipe: directed vector table with
// latency checks, a backpressure stream, reset mid-stream, and a random
// valid/ready stream against a scoreboard. WIDTH=64 unsigned by default,
// WIDTH=8 two's complement when KARATSUBA_SIGNED_EN is defined.
// ---------------------------------------------------------------------------
module tb_karatsuba_mult_pipe;

`ifdef KARATSUBA_SIGNED_EN
    localparam int unsigned W  = 8;
    localparam int unsigned NV = 8;
`else
    localparam int unsigned W  = 64;
    localparam int unsigned NV = 9;
`endif
    localparam int unsigned TW = 4;
    localparam int unsigned LW = 2 * W;

    typedef struct {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [TW-1:0] tag;
        logic [LW-1:0] exp;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    karatsuba_mult_pipe_if #(.WIDTH(W), .TAG_W(TW)) bus ();

    karatsuba_mult_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef KARATSUBA_SIGNED_EN
        logic signed [LW-1:0] sa, sb, p;
        sa = $signed(a);
        sb = $signed(b);
        p  = sa * sb;
        return p;
`else
        logic [LW-1:0] ea, eb;
        ea = {{W{1'b0}}, a};
        eb = {{W{1'b0}}, b};
        return ea * eb;
`endif
    endfunction

    function automatic logic [W-1:0] rand_op();
        logic [63:0] r;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 7))
            0:       return '1;
            1:       return '0;
            2:       return {1'b1, {(W-1){1'b0}}};
            default: return r[W-1:0];
        endcase
    endfunction

    // Streams n items; rnd=0 gives back-to-back input with out_ready low on
    // cycles 4..8, rnd=1 randomises both valid and ready.
    task automatic run_stream(input int n, input bit rnd, input int budget);
        logic [LW-1:0] exp_p [$];
        logic [TW-1:0] exp_t [$];
        logic [LW-1:0] held_p;
        logic [TW-1:0] held_t;
        logic [W-1:0]  na, nb;
        logic [TW-1:0] nt;
        int sent, got, inflight, cyc;
        bit stalled;
        sent = 0; got = 0; inflight = 0; cyc = 0; stalled = 0;
        held_p = '0; held_t = '0; nt = '0;
        na = rnd ? rand_op() : {W{1'b1}};
        nb = rnd ? rand_op() : W'(3);
        while (got < n && cyc < budget) begin
            @(negedge clk);
            if (rnd) bus.out_ready = ($urandom_range(0, 3) != 0);
            else     bus.out_ready = !(cyc >= 4 && cyc <= 8);
            bus.in_valid = (sent < n) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
            bus.in_a     = na;
            bus.in_b     = nb;
            bus.in_tag   = nt;
            #1;
            if (stalled) begin
                chk("stall_valid", LW'(bus.out_valid), LW'(1));
                chk("stall_product", bus.out_product, held_p);
                chk("stall_tag", LW'(bus.out_tag), LW'(held_t));
            end
            chk("in_ready", LW'(bus.in_ready), LW'(bus.out_ready || inflight < 3));
            if (bus.out_valid && bus.out_ready) begin
                chk("out_expected", LW'(exp_p.size() != 0), LW'(1));
                if (exp_p.size() != 0) begin
                    chk("stream_product", bus.out_product, exp_p.pop_front());
                    chk("stream_tag", LW'(bus.out_tag), LW'(exp_t.pop_front()));
                end
                got++;
                inflight--;
            end
            stalled = bus.out_valid && !bus.out_ready;
            held_p  = bus.out_product;
            held_t  = bus.out_tag;
            if (bus.in_valid && bus.in_ready) begin
                exp_p.push_back(ref_mul(na, nb));
                exp_t.push_back(nt);
                sent++;
                inflight++;
                nt = nt + 1'b1;
                na = rnd ? rand_op() : na - W'(sent * 7);
                nb = rnd ? rand_op() : nb + W'(sent * 5);
            end
            cyc++;
        end
        bus.in_valid = 1'b0;
        chk("stream_count", LW'(got), LW'(n));
    endtask

    vec_t vecs [NV];

    initial begin
        checks = 0;
        failures = 0;
`ifdef KARATSUBA_SIGNED_EN
        vecs[0] = '{8'h80, 8'h80, 4'h1, 16'h4000};
        vecs[1] = '{8'hFD, 8'h05, 4'h2, 16'hFFF1};
        vecs[2] = '{8'h7F, 8'h80, 4'h3, 16'hC080};
        vecs[3] = '{8'hFF, 8'hFF, 4'h4, 16'h0001};
        vecs[4] = '{8'h00, 8'hFF, 4'h5, 16'h0000};
        vecs[5] = '{8'h7F, 8'h7F, 4'h6, 16'h3F01};
        vecs[6] = '{8'h80, 8'h01, 4'h7, 16'hFF80};
        vecs[7] = '{8'h05, 8'hFD, 4'h8, 16'hFFF1};
`else
        vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 4'h1,
                    128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001};
        vecs[1] = '{64'h0000_0001_FFFF_FFFF, 64'hFFFF_FFFF_0000_0001, 4'h2,
                    128'h0000_0001_FFFF_FFFD_0000_0002_FFFF_FFFF};
        vecs[2] = '{64'h0, 64'hDEAD_BEEF_CAFE_BABE, 4'h3, 128'h0};
        vecs[3] = '{64'h1, 64'hDEAD_BEEF_CAFE_BABE, 4'h4,
                    128'h0000_0000_0000_0000_DEAD_BEEF_CAFE_BABE};
        vecs[4] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 4'h5,
                    128'h4000_0000_0000_0000_0000_0000_0000_0000};
        vecs[5] = '{64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 4'h6,
                    128'h0000_0000_0000_0000_FFFF_FFFE_0000_0001};
        vecs[6] = '{64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_0000_0000, 4'h7,
                    128'hFFFF_FFFE_0000_0001_0000_0000_0000_0000};
        vecs[7] = '{64'h8000_0000_8000_0000, 64'h2, 4'h8,
                    128'h0000_0000_0000_0001_0000_0001_0000_0000};
        vecs[8] = '{64'h1234_5678, 64'h1000, 4'h9,
                    128'h0000_0000_0000_0000_0000_0123_4567_8000};
`endif

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_out_valid", LW'(bus.out_valid), LW'(0));
        chk("reset_busy", LW'(bus.busy), LW'(0));
        chk("reset_product", bus.out_product, LW'(0));
        chk("reset_tag", LW'(bus.out_tag), LW'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_in_ready", LW'(bus.in_ready), LW'(1));

        // Directed vectors, one at a time, with latency check.
        bus.out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_a     = vecs[i].a;
            bus.in_b     = vecs[i].b;
            bus.in_tag   = vecs[i].tag;
            #1;
            chk("vec_in_ready", LW'(bus.in_ready), LW'(1));
            @(negedge clk);
            bus.in_valid = 1'b0;
            chk("vec_lat1", LW'(bus.out_valid), LW'(0));
            @(negedge clk);
            chk("vec_lat2", LW'(bus.out_valid), LW'(0));
            @(negedge clk);
            chk("vec_valid", LW'(bus.out_valid), LW'(1));
            chk("vec_product", bus.out_product, vecs[i].exp);
            chk("vec_tag", LW'(bus.out_tag), LW'(vecs[i].tag));
        end

        // Backpressure stream: tags 0..9, output stalled on cycles 4..8.
        run_stream(10, 1'b0, 200);

        // Reset with three items in flight.
        @(negedge clk);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = W'(i + 11);
            bus.in_b     = W'(i + 5);
            bus.in_tag   = TW'(i);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        #1;
        chk("t4_full_busy", LW'(bus.busy), LW'(1));
        chk("t4_full_valid", LW'(bus.out_valid), LW'(1));
        chk("t4_full_in_ready", LW'(bus.in_ready), LW'(0));
        rst = 1'b1;
        #1;
        chk("t4_rst_out_valid", LW'(bus.out_valid), LW'(0));
        chk("t4_rst_busy", LW'(bus.busy), LW'(0));
        chk("t4_rst_product", bus.out_product, LW'(0));
        chk("t4_rst_in_ready", LW'(bus.in_ready), LW'(1));
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            #1;
            chk("t4_no_ghost", LW'(bus.out_valid), LW'(0));
        end

        // Random valid/ready stream against the scoreboard.
        run_stream(3000, 1'b1, 30000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
